core_wr_arbiter: RTL and testbench
==================================

CORE_WR_ARBITER -- requirements
Module: core_wr_arbiter

Interface
REQ-001 Parameter N_CORES, default `N_CORES, number of cores sharing the memory write port (1..4).
REQ-002 Parameter WORDS, default 4, words per saved context (A D C B).
REQ-003 Parameter TIMEOUT, default 15, maximum idle cycles between grant/strobes before abort (1..255).
REQ-004 CLK  input  1  sole clock; all logic on posedge.
REQ-005 RST  input  1  synchronous reset, active-high.
REQ-006 core_wr_req  input  N_CORES  per-core: finished context ready for writeback; held until burst_done or abort.
REQ-007 core_dout_en  input  N_CORES  per-core word strobe; only the granted core may assert.
REQ-008 ext_wr_en  input  1  host write into memory this cycle.
REQ-009 core_wr_grant  output  N_CORES  one-hot registered grant; all-zero when idle.
REQ-010 core_num  output  2  index of granted core; valid while burst_active.
REQ-011 burst_active  output  1  high in GRANT and XFER.
REQ-012 word_cnt  output  2  strobes accepted in current burst (0..WORDS-1).
REQ-013 burst_done  output  1  one-cycle pulse after the WORDS-th strobe.
REQ-014 ext_full  output  1  registered backpressure to host writer.
REQ-015 err  output  1  sticky error flag.

Function
REQ-016 FSM states IDLE, GRANT, XFER, DONE; encoding left to synthesis.
REQ-017 IDLE: if |core_wr_req and ~ext_wr_en -> GRANT, core_wr_grant set next cycle to first requester at or after rr_ptr (wrapping mod N_CORES).
REQ-018 IDLE with ext_wr_en=1: no grant issued that cycle; grant deferred by exactly one cycle per ext_wr_en cycle.
REQ-019 ext_full = 1 on the cycle after entering GRANT through the cycle after leaving XFER; 0 otherwise.
REQ-020 GRANT: first strobe from granted core -> XFER, word_cnt=1; strobes may have arbitrary gaps.
REQ-021 XFER: each granted strobe increments word_cnt; WORDS-th strobe -> DONE, word_cnt wraps to 0.
REQ-022 DONE (one cycle): burst_done=1, core_wr_grant=0, rr_ptr <= granted index + 1 mod N_CORES, -> IDLE.
REQ-023 Minimum spacing between consecutive grants: 2 cycles (DONE, IDLE).
REQ-024 Idle counter reset on grant and on each strobe; reaching TIMEOUT in GRANT/XFER: err<=1, grant dropped, -> IDLE, rr_ptr advanced, no burst_done.
REQ-025 Granted core drops core_wr_req in GRANT before any strobe: silent abort to IDLE, no err, rr_ptr unchanged.
REQ-026 Drop of core_wr_req in XFER: err<=1, abort to IDLE.
REQ-027 Strobe from any non-granted core, or >1 strobe bit set in one cycle: err<=1; the strobe is not counted.
REQ-028 Strobe with ext_wr_en=1 in the same cycle: err<=1 (host ignored ext_full).
REQ-029 N_CORES=1: rr_ptr constant 0; core_num upper bits 0.
REQ-030 err clears only on RST.

Reset
REQ-031 RST=1: state IDLE, rr_ptr=0, word_cnt=0, idle counter=0, core_wr_grant=0, burst_active=0, burst_done=0, ext_full=0, err=0, next cycle.
REQ-032 RST mid-burst aborts without burst_done; strobes during RST ignored.
REQ-033 RST takes priority over all same-cycle events.

Structure
REQ-034 State encodings, WORDS default and TIMEOUT default defined in md5.vh alongside N_CORES.
REQ-035 One sub-module rr_pick: combinational round-robin selector (req vector, rr_ptr -> one-hot + index).
REQ-036 No memory access in this block; memory consumes core_num, word_cnt, burst_active.

Verification
REQ-037 N_CORES=3, req=3'b111, rr_ptr=0, each core strobes 4 words back-to-back -> grant order 001,010,100; three burst_done pulses; err=0.
REQ-038 Core 1 strobes with 3 idle cycles between words -> word_cnt 1,2,3,0; burst_done exactly once; ext_full high throughout.
REQ-039 ext_wr_en held 2 cycles while req=001 in IDLE -> grant delayed 2 cycles; no err.
REQ-040 Grant core 0, no strobe for TIMEOUT=15 cycles -> err=1, grant 0, next grant to core 1 when req=011.
REQ-041 Core 2 strobes while core 0 granted -> err=1, word_cnt unchanged.
REQ-042 RST asserted after 2nd word of burst -> all outputs reset values next cycle, no burst_done, next grant to core 0.

Source files
------------

// File: rtl/core_wr_arbiter_pkg.sv
// Shared types and defaults for the core writeback arbiter and its round-robin picker.
package core_wr_arbiter_pkg;

  localparam int N_CORES_DEF = 4;
  localparam int WORDS_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_XFER,
    ST_DONE
  } arb_state_e;

  // Next core index after v, wrapping at n cores.
  function automatic logic [1:0] wrap_inc(input logic [1:0] v, input int n);
    if (int'(v) >= n - 1) return 2'd0;
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/core_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr, wrapping.
module rr_pick
  import core_wr_arbiter_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF
) (
  input  logic [N_CORES-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic [N_CORES-1:0] grant,
  output logic [1:0]         idx
);

  logic               found;
  logic [N_CORES-1:0] shifted;

  always_comb begin
    int j;
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    shifted = '0;
    for (int k = 0; k < N_CORES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_CORES) j = j - N_CORES;
      shifted = req >> j;
      if (!found && shifted[0]) begin
        found = 1'b1;
        grant = N_CORES'(1) << j;
        idx   = 2'(j);
      end
    end
  end

endmodule

// File: rtl/core_wr_arbiter.sv
// Arbitrates the shared memory write port between cores writing back saved contexts.
module core_wr_arbiter
  import core_wr_arbiter_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int WORDS   = WORDS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_CORES-1:0] core_wr_req,
  input  logic [N_CORES-1:0] core_dout_en,
  input  logic               ext_wr_en,
  output logic [N_CORES-1:0] core_wr_grant,
  output logic [1:0]         core_num,
  output logic               burst_active,
  output logic [1:0]         word_cnt,
  output logic               burst_done,
  output logic               ext_full,
  output logic               err
);

  arb_state_e         state, state_n;
  logic [N_CORES-1:0] grant_n, pick_grant;
  logic [1:0]         core_num_n, pick_idx, rr_ptr, rr_ptr_n, word_cnt_n;
  logic [7:0]         idle_cnt, idle_n;
  logic               done_n, err_n, in_burst, good_strobe, req_held, timeout_hit;

  rr_pick #(.N_CORES(N_CORES)) u_pick (
    .req    (core_wr_req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  assign in_burst     = (state == ST_GRANT) || (state == ST_XFER);
  assign burst_active = in_burst;
  assign good_strobe  = in_burst && (|core_dout_en) && (core_dout_en == core_wr_grant);
  assign req_held     = |(core_wr_req & core_wr_grant);
  assign timeout_hit  = (idle_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_n    = state;
    grant_n    = core_wr_grant;
    core_num_n = core_num;
    rr_ptr_n   = rr_ptr;
    word_cnt_n = word_cnt;
    idle_n     = idle_cnt;
    done_n     = 1'b0;
    // Misdirected or multi-bit strobes, and strobes colliding with a host write.
    err_n      = err | ((|core_dout_en) && (!good_strobe || ext_wr_en));
    case (state)
      ST_IDLE: begin
        if ((|core_wr_req) && !ext_wr_en) begin
          state_n    = ST_GRANT;
          grant_n    = pick_grant;
          core_num_n = pick_idx;
          word_cnt_n = '0;
          idle_n     = '0;
        end
      end
      ST_GRANT, ST_XFER: begin
        if (!req_held && (state == ST_XFER || !good_strobe)) begin
          // Withdrawal before the first word is benign; mid-burst it loses data.
          state_n    = ST_IDLE;
          grant_n    = '0;
          word_cnt_n = '0;
          idle_n     = '0;
          if (state == ST_XFER) begin
            err_n    = 1'b1;
            rr_ptr_n = wrap_inc(core_num, N_CORES);
          end
        end else if (good_strobe) begin
          idle_n = '0;
          if (word_cnt == 2'(WORDS - 1)) begin
            state_n    = ST_DONE;
            grant_n    = '0;
            word_cnt_n = '0;
            done_n     = 1'b1;
          end else begin
            state_n    = ST_XFER;
            word_cnt_n = word_cnt + 2'd1;
          end
        end else if (timeout_hit) begin
          state_n    = ST_IDLE;
          grant_n    = '0;
          word_cnt_n = '0;
          idle_n     = '0;
          err_n      = 1'b1;
          rr_ptr_n   = wrap_inc(core_num, N_CORES);
        end else begin
          idle_n = idle_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        state_n  = ST_IDLE;
        rr_ptr_n = wrap_inc(core_num, N_CORES);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      core_wr_grant <= '0;
      core_num      <= '0;
      rr_ptr        <= '0;
      word_cnt      <= '0;
      idle_cnt      <= '0;
      burst_done    <= 1'b0;
      ext_full      <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_n;
      core_wr_grant <= grant_n;
      core_num      <= core_num_n;
      rr_ptr        <= rr_ptr_n;
      word_cnt      <= word_cnt_n;
      idle_cnt      <= idle_n;
      burst_done    <= done_n;
      ext_full      <= in_burst;
      err           <= err_n;
    end
  end

endmodule

// File: tb/tb_core_wr_arbiter.sv
// Randomized and directed bench for core_wr_arbiter against a burst-level reference model.
module tb_core_wr_arbiter;

  localparam int N  = 3;
  localparam int W  = 4;
  localparam int TO = 15;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] core_wr_req, core_dout_en, core_wr_grant;
  logic       ext_wr_en;
  logic [1:0] core_num, word_cnt;
  logic       burst_active, burst_done, ext_full, err;

  core_wr_arbiter #(.N_CORES(N), .WORDS(W), .TIMEOUT(TO)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .core_wr_req   (core_wr_req),
    .core_dout_en  (core_dout_en),
    .ext_wr_en     (ext_wr_en),
    .core_wr_grant (core_wr_grant),
    .core_num      (core_num),
    .burst_active  (burst_active),
    .word_cnt      (word_cnt),
    .burst_done    (burst_done),
    .ext_full      (ext_full),
    .err           (err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0, d_done = 0;

  // Reference model: who owns the port, how far the burst got, and pending bookkeeping.
  int         m_owner = -1, m_last = 0, m_words = 0, m_idle = 0, m_ptr = 0;
  bit         m_started = 0, m_err = 0, m_done = 0, m_full = 0;
  logic [2:0] m_release = '0;

  function automatic bit bit_of(input logic [2:0] v, input int i);
    return ((v >> i) & 3'd1) != 3'd0;
  endfunction

  function automatic logic [2:0] oh(input int i);
    return 3'(1 << i);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic abort_burst(input bit with_err);
    if (with_err) begin
      m_err = 1;
      m_ptr = (m_owner + 1) % N;
    end
    m_release |= oh(m_owner);
    m_owner = -1;
    m_words = 0;
    m_idle  = 0;
  endtask

  task automatic model_step();
    bit was_active, good, held;
    if (RST) begin
      m_owner = -1; m_started = 0; m_words = 0; m_idle = 0; m_ptr = 0;
      m_err = 0; m_done = 0; m_full = 0;
      return;
    end
    was_active = (m_owner >= 0);
    good = was_active && (core_dout_en == oh(m_owner));
    if (core_dout_en != 3'd0 && (!good || ext_wr_en)) m_err = 1;
    if (m_done) begin
      m_done = 0;
      m_ptr  = (m_last + 1) % N;
    end else if (!was_active) begin
      if (core_wr_req != 3'd0 && !ext_wr_en) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && bit_of(core_wr_req, (m_ptr + k) % N)) m_owner = (m_ptr + k) % N;
        end
        m_started = 0; m_words = 0; m_idle = 0;
      end
    end else begin
      held = bit_of(core_wr_req, m_owner);
      if (m_started && !held) abort_burst(1);
      else if (!m_started && !held && !good) abort_burst(0);
      else if (good) begin
        m_idle = 0;
        m_started = 1;
        m_words++;
        if (m_words == W) begin
          m_done = 1;
          m_last = m_owner;
          m_release |= oh(m_owner);
          m_owner = -1;
          m_words = 0;
        end
      end else if (m_idle + 1 == TO) abort_burst(1);
      else m_idle++;
    end
    m_full = was_active;
  endtask

  task automatic cyc();
    model_step();
    @(posedge CLK);
    #1;
    if (burst_done) d_done++;
    check_eq("grant", 32'(core_wr_grant), (m_owner >= 0) ? 32'(oh(m_owner)) : 32'd0);
    check_eq("active", 32'(burst_active), 32'(m_owner >= 0));
    check_eq("word_cnt", 32'(word_cnt), 32'(m_words));
    check_eq("done", 32'(burst_done), 32'(m_done));
    check_eq("ext_full", 32'(ext_full), 32'(m_full));
    check_eq("err", 32'(err), 32'(m_err));
    if (m_owner >= 0) check_eq("core_num", 32'(core_num), 32'(m_owner));
  endtask

  task automatic do_reset();
    RST = 1; core_wr_req = '0; core_dout_en = '0; ext_wr_en = 0;
    cyc();
    RST = 0;
    check_eq("rst_grant", 32'(core_wr_grant), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_full", 32'(ext_full), 32'd0);
  endtask

  task automatic run_burst(input int c, input int gap);
    int waited = 0;
    while (m_owner != c && waited < 8) begin
      cyc();
      waited++;
    end
    check_eq("grant_order", 32'(core_wr_grant), 32'(oh(c)));
    for (int w = 0; w < W; w++) begin
      repeat (gap) begin
        cyc();
        check_eq("full_in_gap", 32'(ext_full), 32'd1);
      end
      core_dout_en = oh(c);
      cyc();
      core_dout_en = '0;
      check_eq("word_seq", 32'(word_cnt), 32'((w + 1) % W));
    end
    check_eq("burst_done", 32'(burst_done), 32'd1);
    core_wr_req = core_wr_req & ~oh(c);
    cyc();
    check_eq("done_one_cycle", 32'(burst_done), 32'd0);
  endtask

  initial begin
    int prev_owner = -1;
    bit silent = 0;
    RST = 1; core_wr_req = '0; core_dout_en = '0; ext_wr_en = 0;

    // Three cores, back-to-back bursts, visited in round-robin order.
    do_reset();
    core_wr_req = 3'b111;
    d_done = 0;
    for (int c = 0; c < N; c++) run_burst(c, 0);
    check_eq("three_dones", 32'(d_done), 32'd3);
    check_eq("rr_err", 32'(err), 32'd0);

    // Slow core with idle gaps between words.
    do_reset();
    core_wr_req = 3'b010;
    d_done = 0;
    run_burst(1, 3);
    cyc();
    check_eq("slow_one_done", 32'(d_done), 32'd1);

    // Host writes defer the grant one cycle each.
    do_reset();
    core_wr_req = 3'b001; ext_wr_en = 1;
    cyc(); check_eq("defer1", 32'(core_wr_grant), 32'd0);
    cyc(); check_eq("defer2", 32'(core_wr_grant), 32'd0);
    ext_wr_en = 0;
    cyc(); check_eq("defer_grant", 32'(core_wr_grant), 32'b001);
    check_eq("defer_err", 32'(err), 32'd0);

    // Timeout on a silent granted core passes the turn on.
    do_reset();
    core_wr_req = 3'b011;
    cyc(); check_eq("to_grant", 32'(core_wr_grant), 32'b001);
    repeat (TO - 1) cyc();
    check_eq("to_not_yet", 32'(err), 32'd0);
    cyc();
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_drop", 32'(core_wr_grant), 32'd0);
    cyc(); check_eq("to_next", 32'(core_wr_grant), 32'b010);

    // Foreign strobe is flagged and not counted.
    do_reset();
    core_wr_req = 3'b001;
    cyc();
    core_dout_en = 3'b001; cyc();
    core_dout_en = 3'b100; cyc();
    core_dout_en = '0;
    check_eq("foreign_err", 32'(err), 32'd1);
    check_eq("foreign_cnt", 32'(word_cnt), 32'd1);

    // Reset mid-burst drops everything and restarts the rotation at core 0.
    do_reset();
    core_wr_req = 3'b001;
    run_burst(0, 0);
    core_wr_req = 3'b011;
    cyc(); cyc();
    check_eq("mid_grant", 32'(core_wr_grant), 32'b010);
    core_dout_en = 3'b010; cyc(); cyc();
    RST = 1; d_done = 0; cyc();
    RST = 0; core_dout_en = '0;
    check_eq("mid_grant0", 32'(core_wr_grant), 32'd0);
    check_eq("mid_active0", 32'(burst_active), 32'd0);
    check_eq("mid_cnt0", 32'(word_cnt), 32'd0);
    check_eq("mid_nodone", 32'(d_done), 32'd0);
    cyc();
    check_eq("mid_regrant", 32'(core_wr_grant), 32'b001);

    // Randomized traffic against the model.
    do_reset();
    m_release = '0;
    for (int t = 0; t < 4000; t++) begin
      core_wr_req = core_wr_req & ~m_release;
      m_release = '0;
      if (m_owner != prev_owner) begin
        if (m_owner >= 0) silent = ($urandom_range(0, 7) == 0);
        prev_owner = m_owner;
      end
      for (int c = 0; c < N; c++)
        if (!bit_of(core_wr_req, c) && $urandom_range(0, 3) == 0) core_wr_req = core_wr_req | oh(c);
      core_dout_en = '0; ext_wr_en = 0; RST = 0;
      if (m_owner >= 0 && !silent) begin
        if (!m_started && $urandom_range(0, 39) == 0) core_wr_req = core_wr_req & ~oh(m_owner);
        else if ($urandom_range(0, 1) == 0) core_dout_en = oh(m_owner);
      end
      if (core_dout_en == 3'd0) begin
        if ($urandom_range(0, 4) == 0) ext_wr_en = 1;
        else if ($urandom_range(0, 79) == 0) core_dout_en = 3'($urandom_range(1, 7));
      end
      if ($urandom_range(0, 399) == 0) RST = 1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
